// File: rtl/mac_tbl_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_tbl_arbiter_if
// Description : Lookup, management and RAM-side signal bundle of the MAC table arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_tbl_arbiter_if;
  logic        i_lu_req;
  logic        o_lu_gnt;
  logic        i_lu_ram_rd;
  logic [4:0]  iv_lu_ram_raddr;
  logic        o_lu_err;
  logic        i_cfg_req;
  logic        i_cfg_wr;
  logic [4:0]  iv_cfg_addr;
  logic [56:0] iv_cfg_wdata;
  logic        o_cfg_ack;
  logic [56:0] ov_cfg_rdata;
  logic        o_ram_rd;
  logic        o_ram_wr;
  logic [4:0]  ov_ram_addr;
  logic [56:0] ov_ram_wdata;
  logic [56:0] iv_ram_rdata;
  logic [56:0] ov_lu_ram_rdata;

  modport slave (
    input  i_lu_req, i_lu_ram_rd, iv_lu_ram_raddr,
    input  i_cfg_req, i_cfg_wr, iv_cfg_addr, iv_cfg_wdata,
    input  iv_ram_rdata,
    output o_lu_gnt, o_lu_err, o_cfg_ack, ov_cfg_rdata,
    output o_ram_rd, o_ram_wr, ov_ram_addr, ov_ram_wdata, ov_lu_ram_rdata
  );

  modport master (
    output i_lu_req, i_lu_ram_rd, iv_lu_ram_raddr,
    output i_cfg_req, i_cfg_wr, iv_cfg_addr, iv_cfg_wdata,
    output iv_ram_rdata,
    input  o_lu_gnt, o_lu_err, o_cfg_ack, ov_cfg_rdata,
    input  o_ram_rd, o_ram_wr, ov_ram_addr, ov_ram_wdata, ov_lu_ram_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mac_tbl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mac_tbl_arbiter
// Description : Arbitrates the single MAC-table RAM port between the lookup
//               engine and management accesses. Define MAC_TBL_CFG_RD_EN to
//               build management reads through the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_tbl_arbiter #(
  parameter int LU_HOLD_MAX = 40
) (
  input wire               i_clk,
  input wire               i_rst,
  mac_tbl_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(LU_HOLD_MAX + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LU_S       = 3'd1,
    CFG_WR_S   = 3'd2,
    CFG_RD_S   = 3'd3,
    CFG_WAIT_S = 3'd4,
    CFG_CAP_S  = 3'd5,
    ACK_S      = 3'd6
  } state_t;

  state_t             r_state;
  logic               r_last_cfg;
  logic               r_rearm;
  logic               r_cfg_block;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [4:0]         r_cfg_addr;
  logic [56:0]        r_cfg_wdata;
  logic               r_lu_gnt;
  logic               r_lu_err;
  logic               r_cfg_ack;
  logic [56:0]        r_cfg_rdata;

  logic               w_lu_req;
  logic               w_cfg_req;

  // A timed-out lookup stays ineligible until its request has been seen low.
  assign w_lu_req  = bus.i_lu_req && r_rearm;
  assign w_cfg_req = bus.i_cfg_req && !r_cfg_block;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_last_cfg  <= 1'b1;
      r_rearm     <= 1'b1;
      r_cfg_block <= 1'b0;
      r_hold_cnt  <= '0;
      r_cfg_addr  <= '0;
      r_cfg_wdata <= '0;
      r_lu_gnt    <= 1'b0;
      r_lu_err    <= 1'b0;
      r_cfg_ack   <= 1'b0;
      r_cfg_rdata <= '0;
    end else begin
      r_lu_err  <= 1'b0;
      r_cfg_ack <= 1'b0;
      if (!bus.i_lu_req) begin
        r_rearm <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_cfg_block <= 1'b0;
          r_hold_cnt  <= '0;
          if (w_lu_req && (!w_cfg_req || r_last_cfg)) begin
            r_state  <= LU_S;
            r_lu_gnt <= 1'b1;
          end else if (w_cfg_req) begin
            r_cfg_addr  <= bus.iv_cfg_addr;
            r_cfg_wdata <= bus.iv_cfg_wdata;
            if (bus.i_cfg_wr) begin
              r_state <= CFG_WR_S;
            end else begin
`ifdef MAC_TBL_CFG_RD_EN
              r_state <= CFG_RD_S;
`else
              r_state     <= ACK_S;
              r_cfg_ack   <= 1'b1;
              r_cfg_rdata <= '0;
`endif
            end
          end
        end
        LU_S: begin
          if (!bus.i_lu_req) begin
            r_state    <= IDLE;
            r_lu_gnt   <= 1'b0;
            r_last_cfg <= 1'b0;
          end else if (r_hold_cnt == CNT_W'(LU_HOLD_MAX - 1)) begin
            r_state    <= IDLE;
            r_lu_gnt   <= 1'b0;
            r_lu_err   <= 1'b1;
            r_last_cfg <= 1'b0;
            r_rearm    <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        CFG_WR_S: begin
          r_state   <= ACK_S;
          r_cfg_ack <= 1'b1;
        end
`ifdef MAC_TBL_CFG_RD_EN
        CFG_RD_S: begin
          r_state <= CFG_WAIT_S;
        end
        CFG_WAIT_S: begin
          r_state <= CFG_CAP_S;
        end
        // RAM data for the read issued two cycles ago is valid now.
        CFG_CAP_S: begin
          r_state     <= ACK_S;
          r_cfg_rdata <= bus.iv_ram_rdata;
          r_cfg_ack   <= 1'b1;
        end
`endif
        ACK_S: begin
          r_state     <= IDLE;
          r_last_cfg  <= 1'b1;
          r_cfg_block <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef MAC_TBL_CFG_RD_EN
  assign bus.o_ram_rd = (r_state == LU_S) ? bus.i_lu_ram_rd : (r_state == CFG_RD_S);
`else
  assign bus.o_ram_rd = (r_state == LU_S) && bus.i_lu_ram_rd;
`endif
  assign bus.o_ram_wr     = (r_state == CFG_WR_S);
  assign bus.ov_ram_wdata = (r_state == CFG_WR_S) ? r_cfg_wdata : 57'h0;

  always_comb begin
    bus.ov_ram_addr = 5'h00;
    case (r_state)
      LU_S:     bus.ov_ram_addr = bus.iv_lu_ram_raddr;
      CFG_WR_S: bus.ov_ram_addr = r_cfg_addr;
`ifdef MAC_TBL_CFG_RD_EN
      CFG_RD_S: bus.ov_ram_addr = r_cfg_addr;
`endif
      default:  bus.ov_ram_addr = 5'h00;
    endcase
  end

  assign bus.o_lu_gnt        = r_lu_gnt;
  assign bus.o_lu_err        = r_lu_err;
  assign bus.o_cfg_ack       = r_cfg_ack;
  assign bus.ov_cfg_rdata    = r_cfg_rdata;
  assign bus.ov_lu_ram_rdata = bus.iv_ram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mac_tbl_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_tbl_arbiter
// Description : Self-checking bench for mac_tbl_arbiter with a 2-cycle RAM model
//               and a shadow table of expected entry contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_tbl_arbiter;

  localparam int HOLD = 40;
`ifdef MAC_TBL_CFG_RD_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  logic [56:0] mem    [0:31];
  logic [56:0] shadow [0:31];
  logic [56:0] p1;
  logic [56:0] p2;

  mac_tbl_arbiter_if bus ();

  mac_tbl_arbiter #(.LU_HOLD_MAX(HOLD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: write on the strobe edge, read data valid two cycles after the read strobe.
  always @(posedge clk) begin
    if (bus.o_ram_wr) mem[bus.ov_ram_addr] <= bus.ov_ram_wdata;
    p1 <= bus.o_ram_rd ? mem[bus.ov_ram_addr] : 57'h0;
    p2 <= p1;
  end
  assign bus.iv_ram_rdata = p2;

  function automatic logic [56:0] rand57();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[56:0];
  endfunction

  function automatic logic [4:0] rand5();
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_lu_req  = 1'b1;
    bus.i_cfg_req = 1'b1;
    tick();
    tick();
    #1;
    tests++;
    if ({bus.o_lu_gnt, bus.o_lu_err, bus.o_cfg_ack, bus.o_ram_rd, bus.o_ram_wr} !== 5'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {bus.o_lu_gnt, bus.o_lu_err, bus.o_cfg_ack, bus.o_ram_rd, bus.o_ram_wr});
    end
    tests++;
    if (bus.ov_cfg_rdata !== 57'h0) begin
      fails++;
      $display("FAIL reset_rdata: got %h expected 0", bus.ov_cfg_rdata);
    end
    bus.i_lu_req  = 1'b0;
    bus.i_cfg_req = 1'b0;
    rst = 1'b0;
    tick();
    #1;
    tests++;
    if (bus.o_lu_gnt !== 1'b0 || bus.o_cfg_ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: gnt %b ack %b expected 0 0", bus.o_lu_gnt, bus.o_cfg_ack);
    end
  endtask

  task automatic test_lookup_alone();
    logic [4:0] a;
    bus.i_lu_req = 1'b1;
    #1;
    tests++;
    if (bus.o_lu_gnt !== 1'b0) begin
      fails++;
      $display("FAIL lu_gnt_c0: got %b expected 0", bus.o_lu_gnt);
    end
    tick();
    #1;
    tests++;
    if (bus.o_lu_gnt !== 1'b1) begin
      fails++;
      $display("FAIL lu_gnt_c1: got %b expected 1", bus.o_lu_gnt);
    end
    for (int c = 2; c <= 9; c++) begin
      tick();
      a = (c == 2) ? 5'h03 : rand5();
      bus.i_lu_ram_rd     = 1'b1;
      bus.iv_lu_ram_raddr = a;
      #1;
      tests++;
      if (bus.o_ram_rd !== 1'b1 || bus.o_ram_wr !== 1'b0 || bus.ov_ram_addr !== a) begin
        fails++;
        $display("FAIL lu_addr_follow c%0d: rd %b wr %b addr %h expected 1 0 %h",
                 c, bus.o_ram_rd, bus.o_ram_wr, bus.ov_ram_addr, a);
      end
    end
    tick();
    bus.i_lu_req    = 1'b0;
    bus.i_lu_ram_rd = 1'b0;
    #1;
    tests++;
    if (bus.o_lu_gnt !== 1'b1 || bus.o_ram_rd !== 1'b0) begin
      fails++;
      $display("FAIL lu_c10: gnt %b rd %b expected 1 0", bus.o_lu_gnt, bus.o_ram_rd);
    end
    tick();
    #1;
    tests++;
    if (bus.o_lu_gnt !== 1'b0 || bus.o_lu_err !== 1'b0) begin
      fails++;
      $display("FAIL lu_c11: gnt %b err %b expected 0 0", bus.o_lu_gnt, bus.o_lu_err);
    end
    tick();
  endtask

  // Single management access from idle, inputs scrambled after the grant cycle.
  task automatic cfg_access(input bit wr, input logic [4:0] addr, input logic [56:0] wdata,
                            input bit late_drop);
    int ack_cyc, wr_cyc, rd_cyc, wr_cnt, rd_cnt, extra, exp_ack, exp_strobe, strobe_cyc;
    bit data_ok;
    logic [56:0] exp_rdata, got_rdata;
    ack_cyc = -1; wr_cyc = -1; rd_cyc = -1; wr_cnt = 0; rd_cnt = 0; extra = 0;
    data_ok = 1'b1;
    got_rdata = 57'h0;
    exp_ack    = wr ? 2 : (RD_EN ? 4 : 1);
    exp_strobe = (wr || RD_EN) ? 1 : -1;
    exp_rdata  = RD_EN ? shadow[addr] : 57'h0;
    bus.i_cfg_req    = 1'b1;
    bus.i_cfg_wr     = wr;
    bus.iv_cfg_addr  = addr;
    bus.iv_cfg_wdata = wdata;
    for (int n = 1; n <= 20 && ack_cyc < 0; n++) begin
      tick();
      if (n == 1) begin
        bus.i_cfg_wr     = !wr;
        bus.iv_cfg_addr  = ~addr;
        bus.iv_cfg_wdata = ~wdata;
      end
      #1;
      if (bus.o_ram_wr) begin
        wr_cnt++;
        wr_cyc = n;
        if (bus.ov_ram_addr !== addr || bus.ov_ram_wdata !== wdata) data_ok = 1'b0;
      end
      if (bus.o_ram_rd) begin
        rd_cnt++;
        rd_cyc = n;
        if (bus.ov_ram_addr !== addr) data_ok = 1'b0;
      end
      if (bus.o_cfg_ack) begin
        ack_cyc   = n;
        got_rdata = bus.ov_cfg_rdata;
      end
    end
    if (late_drop) begin
      tick();
      #1;
      if (bus.o_cfg_ack || bus.o_ram_wr || bus.o_ram_rd) extra++;
      tick();
    end
    bus.i_cfg_req = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      #1;
      if (bus.o_cfg_ack || bus.o_ram_wr || bus.o_ram_rd) extra++;
    end
    strobe_cyc = wr ? wr_cyc : rd_cyc;
    tests++;
    if (ack_cyc != exp_ack) begin
      fails++;
      $display("FAIL cfg_ack_cycle wr=%0b addr=%h: got %0d expected %0d", wr, addr, ack_cyc, exp_ack);
    end
    tests++;
    if (wr_cnt != (wr ? 1 : 0) || rd_cnt != ((!wr && RD_EN) ? 1 : 0) ||
        strobe_cyc != exp_strobe || !data_ok) begin
      fails++;
      $display("FAIL cfg_strobe wr=%0b addr=%h: wr_cnt %0d rd_cnt %0d cyc %0d ok %0b expected %0d %0d %0d 1",
               wr, addr, wr_cnt, rd_cnt, strobe_cyc, data_ok, wr ? 1 : 0,
               (!wr && RD_EN) ? 1 : 0, exp_strobe);
    end
    if (!wr) begin
      tests++;
      if (got_rdata !== exp_rdata) begin
        fails++;
        $display("FAIL cfg_rdata addr=%h: got %h expected %h", addr, got_rdata, exp_rdata);
      end
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL cfg_no_double late=%0b: got %0d extra strobes/acks expected 0", late_drop, extra);
    end
    if (wr) shadow[addr] = wdata;
  endtask

  task automatic test_cfg_write();
    cfg_access(1'b1, 5'h07, {9'h004, 48'h0011_2233_4455}, 1'b0);
    cfg_access(1'b0, 5'h07, rand57(), 1'b0);
    cfg_access(1'b1, 5'h12, rand57(), 1'b1);
    cfg_access(1'b0, 5'h12, rand57(), 1'b1);
  endtask

  task automatic test_arbitration();
    bit exp_lu;
    logic [4:0] a;
    logic [56:0] d;
    bit acked;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_lu = 1'b1;
    for (int r = 0; r < 6; r++) begin
      a = rand5();
      d = rand57();
      bus.i_lu_req     = 1'b1;
      bus.i_cfg_req    = 1'b1;
      bus.i_cfg_wr     = 1'b1;
      bus.iv_cfg_addr  = a;
      bus.iv_cfg_wdata = d;
      tick();
      #1;
      tests++;
      if (bus.o_lu_gnt !== exp_lu || bus.o_ram_wr !== !exp_lu) begin
        fails++;
        $display("FAIL arb_round%0d: gnt %b wr %b expected %b %b",
                 r, bus.o_lu_gnt, bus.o_ram_wr, exp_lu, !exp_lu);
      end
      if (bus.o_lu_gnt) begin
        bus.i_cfg_req = 1'b0;
        repeat (3) tick();
        bus.i_lu_req = 1'b0;
      end else begin
        bus.i_lu_req = 1'b0;
        acked = 1'b0;
        for (int k = 0; k < 8 && !acked; k++) begin
          tick();
          #1;
          acked = bus.o_cfg_ack;
        end
        bus.i_cfg_req = 1'b0;
        shadow[a] = d;
      end
      repeat (3) tick();
      exp_lu = !exp_lu;
    end
  endtask

  task automatic test_timeout();
    logic [4:0]  got, expv;
    logic [56:0] d;
    bit eg, ee, ew, ea;
    d = rand57();
    bus.i_lu_req        = 1'b1;
    bus.i_lu_ram_rd     = 1'b1;
    bus.iv_lu_ram_raddr = 5'h1f;
    for (int c = 1; c <= 103; c++) begin
      tick();
      if (c == 5) begin
        bus.i_cfg_req    = 1'b1;
        bus.i_cfg_wr     = 1'b1;
        bus.iv_cfg_addr  = 5'h0a;
        bus.iv_cfg_wdata = d;
      end
      if (c == 100) bus.i_lu_req = 1'b0;
      if (c == 101) bus.i_lu_req = 1'b1;
      #1;
      eg = (c <= HOLD) || (c >= 102);
      ee = (c == HOLD + 1);
      ew = (c == HOLD + 2);
      ea = (c == HOLD + 3);
      expv = {eg, ee, eg, ew, ea};
      got  = {bus.o_lu_gnt, bus.o_lu_err, bus.o_ram_rd, bus.o_ram_wr, bus.o_cfg_ack};
      tests++;
      if (got !== expv) begin
        fails++;
        $display("FAIL timeout c%0d: {gnt,err,rd,wr,ack} got %b expected %b", c, got, expv);
      end
      if (bus.o_cfg_ack) bus.i_cfg_req = 1'b0;
    end
    bus.i_lu_req    = 1'b0;
    bus.i_lu_ram_rd = 1'b0;
    bus.i_cfg_req   = 1'b0;
    shadow[5'h0a] = d;
    repeat (3) tick();
  endtask

  task automatic lu_scan(input int len);
    logic [4:0] ah [0:15];
    bus.i_lu_req = 1'b1;
    tick();
    #1;
    tests++;
    if (bus.o_lu_gnt !== 1'b1) begin
      fails++;
      $display("FAIL scan_gnt: got %b expected 1", bus.o_lu_gnt);
    end
    for (int i = 0; i < len; i++) begin
      ah[i] = rand5();
      bus.i_lu_ram_rd     = 1'b1;
      bus.iv_lu_ram_raddr = ah[i];
      #1;
      tests++;
      if (bus.o_ram_rd !== 1'b1 || bus.o_ram_wr !== 1'b0 || bus.ov_ram_addr !== ah[i]) begin
        fails++;
        $display("FAIL scan_addr: rd %b wr %b addr %h expected 1 0 %h",
                 bus.o_ram_rd, bus.o_ram_wr, bus.ov_ram_addr, ah[i]);
      end
      if (i >= 2) begin
        tests++;
        if (bus.ov_lu_ram_rdata !== shadow[ah[i-2]]) begin
          fails++;
          $display("FAIL scan_rdata addr=%h: got %h expected %h",
                   ah[i-2], bus.ov_lu_ram_rdata, shadow[ah[i-2]]);
        end
      end
      tick();
    end
    bus.i_lu_ram_rd = 1'b0;
    bus.i_lu_req    = 1'b0;
    tick();
    #1;
    tests++;
    if (bus.o_lu_gnt !== 1'b0 || bus.o_lu_err !== 1'b0) begin
      fails++;
      $display("FAIL scan_release: gnt %b err %b expected 0 0", bus.o_lu_gnt, bus.o_lu_err);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0:       cfg_access(1'b1, rand5(), rand57(), 1'($urandom_range(0, 1)));
        1:       cfg_access(1'b0, rand5(), rand57(), 1'($urandom_range(0, 1)));
        default: lu_scan($urandom_range(3, 10));
      endcase
      repeat (2) tick();
    end
  endtask

  task automatic test_reset_mid();
    int abort_cyc;
    logic [56:0] d;
    abort_cyc = RD_EN ? 2 : 1;
    d = rand57();
    bus.i_cfg_req    = 1'b1;
    bus.i_cfg_wr     = !RD_EN;
    bus.iv_cfg_addr  = 5'h11;
    bus.iv_cfg_wdata = d;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == abort_cyc) begin
        rst = 1'b1;
        bus.i_cfg_req = 1'b0;
      end
      if (c == abort_cyc + 2) rst = 1'b0;
      #1;
      if (c > abort_cyc) begin
        tests++;
        if ({bus.o_lu_gnt, bus.o_lu_err, bus.o_cfg_ack, bus.o_ram_rd, bus.o_ram_wr} !== 5'b0 ||
            bus.ov_ram_addr !== 5'h0) begin
          fails++;
          $display("FAIL reset_mid c%0d: {gnt,err,ack,rd,wr} %b addr %h expected 00000 00",
                   c, {bus.o_lu_gnt, bus.o_lu_err, bus.o_cfg_ack, bus.o_ram_rd, bus.o_ram_wr},
                   bus.ov_ram_addr);
        end
      end
    end
    if (!RD_EN) shadow[5'h11] = d;
  endtask

  task automatic test_mem_contents();
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (mem[i] !== shadow[i]) begin
        fails++;
        $display("FAIL mem_entry%0d: got %h expected %h", i, mem[i], shadow[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 32; i++) begin
      mem[i]    = 57'h0;
      shadow[i] = 57'h0;
    end
    rst                 = 1'b1;
    bus.i_lu_req        = 1'b0;
    bus.i_lu_ram_rd     = 1'b0;
    bus.iv_lu_ram_raddr = 5'h0;
    bus.i_cfg_req       = 1'b0;
    bus.i_cfg_wr        = 1'b0;
    bus.iv_cfg_addr     = 5'h0;
    bus.iv_cfg_wdata    = 57'h0;
    test_reset();
    test_lookup_alone();
    test_cfg_write();
    test_arbitration();
    test_timeout();
    test_random();
    test_reset_mid();
    repeat (2) tick();
    test_mem_contents();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
